// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16x4 systolic-stage FIFO.
package fifo_pkg;

  localparam int FIFO_DW    = 16;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  // Read/write pointer: low FIFO_AW bits address the RAM, the MSB is the wrap bit.
  typedef logic [FIFO_AW:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, flag and handshake controller for the one-read/one-write FIFO RAM.
// The RAM registers its read address, so the controller pre-addresses it with
// (rd_ptr + pop) and out_data is simply the RAM read data.
// Optional feature macro: FIFO_LEVEL_EN adds the level and ovf_err outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          ram_wen,
  output logic [AW-1:0] ram_wadr,
  output logic [DW-1:0] ram_wdata,
  output logic [AW-1:0] ram_radr,
  input  logic [DW-1:0] ram_rdata
`ifdef FIFO_LEVEL_EN
  ,
  output logic [AW:0]   level,
  output logic          ovf_err
`endif
);

  localparam logic [AW:0] PTR_ZERO = '0;
  localparam logic [AW:0] PTR_ONE  = 1;

  logic [AW:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0] rd_ptr_ahead;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Flags, handshakes and RAM port drive, all derived from the current pointers.
  always_comb begin
    empty        = (wr_ptr_reg == rd_ptr_reg);
    full         = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    // in_ready depends only on the pointers: no write-through when full.
    in_ready     = !full;
    out_valid    = !empty;
    push         = in_valid && !full && !flush;
    pop          = out_ready && !empty && !flush;

    ram_wen      = push;
    ram_wadr     = wr_ptr_reg[AW-1:0];
    ram_wdata    = in_data;

    // Address the entry that will be the head after this edge; after a flush
    // the head is entry 0.
    rd_ptr_ahead = rd_ptr_reg + (pop ? PTR_ONE : PTR_ZERO);
    ram_radr     = flush ? '0 : rd_ptr_ahead[AW-1:0];
    out_data     = ram_rdata;

    wr_ptr_next  = flush ? PTR_ZERO : (wr_ptr_reg + (push ? PTR_ONE : PTR_ZERO));
    rd_ptr_next  = flush ? PTR_ZERO : rd_ptr_ahead;
  end

  // Pointer registers; reset clears the flags immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

`ifdef FIFO_LEVEL_EN
  logic ovf_err_reg, ovf_err_next;

  // Occupancy and next value of the sticky overflow flag.
  always_comb begin
    level        = wr_ptr_reg - rd_ptr_reg;
    ovf_err_next = flush ? 1'b0 : (ovf_err_reg || (in_valid && full));
    ovf_err      = ovf_err_reg;
  end

  // Sticky overflow: set by an offered word while full, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err_reg <= 1'b0;
    end else begin
      ovf_err_reg <= ovf_err_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural RAM and a queue model.
module tb_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_wen;
  logic [AW-1:0] ram_wadr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_radr;
  logic [DW-1:0] ram_rdata;
`ifdef FIFO_LEVEL_EN
  logic [AW:0]   level;
  logic          ovf_err;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: queue of stored words plus sticky overflow flag.
  logic [DW-1:0] q[$];
  bit            m_ovf = 1'b0;

  always #5 clk = ~clk;

  // Behavioural RAM: registered read address, combinational read data.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] radr_q;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_wadr] <= ram_wdata;
    radr_q <= ram_radr;
  end
  assign ram_rdata = mem[radr_q];

  fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_wen   (ram_wen),
    .ram_wadr  (ram_wadr),
    .ram_wdata (ram_wdata),
    .ram_radr  (ram_radr),
    .ram_rdata (ram_rdata)
`ifdef FIFO_LEVEL_EN
    ,
    .level     (level),
    .ovf_err   (ovf_err)
`endif
  );

  // Apply inputs shortly after an edge and wait until mid-cycle for sampling.
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  // Clock edge: update the model from the applied inputs and the model's own occupancy.
  task automatic advance();
    bit acc, pp;
    @(posedge clk);
    acc = in_valid && (q.size() < DEPTH) && !flush;
    pp  = out_ready && (q.size() > 0) && !flush;
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (ram_wen !== 1'b0) begin fails++; $display("FAIL reset_ram_wen got=%b exp=0", ram_wen); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || ram_wen !== 1'b0) begin
      fails++; $display("FAIL idle_flags got in_ready=%b out_valid=%b ram_wen=%b exp 1/0/0", in_ready, out_valid, ram_wen);
    end
`ifdef FIFO_LEVEL_EN
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL idle_level got=%0d exp=0", level); end
`endif
    advance();
    $display("[TB] test_reset done");
  endtask

  task automatic test_fill();
    logic [DW-1:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      tests++; if (ram_wen !== 1'b1 || ram_wdata !== words[i]) begin
        fails++; $display("FAIL fill_wen[%0d] got wen=%b wdata=%h exp wen=1 wdata=%h", i, ram_wen, ram_wdata, words[i]);
      end
      tests++; if (out_valid !== (q.size() > 0)) begin
        fails++; $display("FAIL fill_out_valid[%0d] got=%b exp=%b", i, out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL fill_head[%0d] got=%h exp=%h", i, out_data, q[0]); end
      end
      advance();
      $display("[TB] push %h size=%0d", words[i], q.size());
    end
    drive(1'b1, 16'h9999, 1'b0, 1'b0);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    tests++; if (ram_wen !== 1'b0) begin fails++; $display("FAIL full_ram_wen got=%b exp=0", ram_wen); end
`ifdef FIFO_LEVEL_EN
    tests++; if (level !== 3'(q.size())) begin fails++; $display("FAIL full_level got=%0d exp=%0d", level, q.size()); end
`endif
    advance();
`ifdef FIFO_LEVEL_EN
    tests++; if (ovf_err !== m_ovf) begin fails++; $display("FAIL ovf_err got=%b exp=%b", ovf_err, m_ovf); end
`endif
    $display("[TB] test_fill done size=%0d", q.size());
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, out_valid, q.size() > 0); end
      tests++; if (in_ready !== (q.size() < DEPTH)) begin fails++; $display("FAIL drain_in_ready[%0d] got=%b exp=%b", i, in_ready, q.size() < DEPTH); end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, out_data, q[0]); end
        $display("[TB] pop %h", q[0]);
      end
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 12; i++) begin
      drive(i < 10, DW'(16'hA000 + i), 1'b1, 1'b0);
      tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL stream_valid[%0d] got=%b exp=%b", i, out_valid, q.size() > 0); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, q[0]); end
        $display("[TB] stream out %h", q[0]);
      end
      advance();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, DW'(16'hB000 + i), 1'b0, 1'b0);
      advance();
    end
    drive(1'b1, 16'hBEEF, 1'b1, 1'b1);
    tests++; if (ram_wen !== 1'b0) begin fails++; $display("FAIL flush_wen got=%b exp=0", ram_wen); end
    advance();
    drive(1'b1, 16'h5555, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL post_flush got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b1 || out_data !== q[0]) begin
      fails++; $display("FAIL flush_repush got valid=%b data=%h exp valid=1 data=%h", out_valid, out_data, q[0]);
    end
    $display("[TB] flush then push %h", q[0]);
    drive(1'b0, '0, 1'b1, 1'b0);
    advance();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, DW'(16'hC000 + i), 1'b0, 1'b0);
      advance();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL async_reset got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
    #1 rst_n = 1'b1;
    q.delete(); m_ovf = 1'b0;
    drive(1'b1, 16'h7777, 1'b0, 1'b0);
    tests++; if (out_valid !== 1'b0 || ram_wen !== 1'b1 || ram_wadr !== 2'd0) begin
      fails++; $display("FAIL after_reset got valid=%b wen=%b wadr=%0d exp 0/1/0", out_valid, ram_wen, ram_wadr);
    end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    tests++; if (out_valid !== 1'b1 || out_data !== 16'h7777) begin
      fails++; $display("FAIL after_reset_data got valid=%b data=%h exp 1/7777", out_valid, out_data);
    end
    advance();
    $display("[TB] test_async_reset done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
      tests++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < DEPTH) ||
          ram_wen !== (in_valid && q.size() < DEPTH && !flush)) begin
        fails++;
        $display("FAIL rand_flags[%0d] got v=%b r=%b w=%b exp v=%b r=%b w=%b", i, out_valid, in_ready, ram_wen,
                 q.size() > 0, q.size() < DEPTH, in_valid && q.size() < DEPTH && !flush);
      end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, out_data, q[0]); end
      end
`ifdef FIFO_LEVEL_EN
      tests++; if (level !== 3'(q.size()) || ovf_err !== m_ovf) begin
        fails++; $display("FAIL rand_level[%0d] got level=%0d ovf=%b exp level=%0d ovf=%b", i, level, ovf_err, q.size(), m_ovf);
      end
`endif
      $display("[TB] rand %0d iv=%b or=%b fl=%b size=%0d", i, in_valid, out_ready, flush, q.size());
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
